// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: start/busy sequencer that issues the load strobe and baud-rate
// shift strobes for the UART TX frame shifter, then signals frame completion.
module uart_tx_ctrl #(
    parameter int DW         = 8,
    parameter int BAUD_DIV   = 5208,
    parameter int NUM_SHIFTS = DW + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_load,
    output logic          o_ena,
    output logic          o_busy,
    output logic          o_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int NW = $clog2(NUM_SHIFTS + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] BIT_LAST = NW'(NUM_SHIFTS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STOP, DONE} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [NW-1:0] bits, bits_n;
    logic [DW-1:0] data_n;
    logic          tick;

    assign tick = baud == BAUD_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            baud   <= '0;
            bits   <= '0;
            o_data <= '0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bits   <= bits_n;
            o_data <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bits_n  = bits;
        data_n  = o_data;
        case (state)
            IDLE: begin
                state_n = i_start ? LOAD : IDLE;
                data_n  = i_start ? i_data : o_data;
            end
            LOAD: begin
                baud_n  = '0;
                bits_n  = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                baud_n  = tick ? '0 : baud + 1'b1;
                bits_n  = tick ? bits + 1'b1 : bits;
                state_n = (tick && bits == BIT_LAST) ? STOP : SHIFT;
            end
            // stop bit: one full bit period with no shift strobe
            STOP: begin
                baud_n  = tick ? '0 : baud + 1'b1;
                state_n = tick ? DONE : STOP;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign o_load = state == LOAD;
    assign o_ena  = state == SHIFT && tick;
    assign o_busy = state != IDLE;
    assign o_done = state == DONE;
endmodule
